enigma_rotor_fwd: RTL and testbench

//  Forward (keyboard-to-reflector) rotor path: the counterpart of the reverse rotor stage.

---
 rtl/enigma_pkg.sv | 83 ++++++++
 rtl/enigma_rotor_fwd_if.sv | 28 ++
 rtl/enigma_rotor_map.sv | 36 +++
 rtl/enigma_rotor_fwd.sv | 167 ++++++++++++++++
 tb/tb_enigma_rotor_fwd.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: letter type, rotor wirings and their inverses,
// mod-26 helpers and the rotor-stage FSM encoding.
package enigma_pkg;

   localparam int unsigned LETTERS = 26;

   typedef logic [4:0] letter_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_R1   = 2'd1,
      ST_R2   = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   localparam letter_t LETTER_LIMIT = 5'd26;

   localparam letter_t W1 [LETTERS] = '{
      5'd9,  5'd6,  5'd3,  5'd16, 5'd14, 5'd23, 5'd20, 5'd18, 5'd2,  5'd0,
      5'd12, 5'd8,  5'd5,  5'd17, 5'd21, 5'd19, 5'd15, 5'd13, 5'd4,  5'd22,
      5'd10, 5'd1,  5'd11, 5'd25, 5'd24, 5'd7
   };

   localparam letter_t W2 [LETTERS] = '{
      5'd13, 5'd19, 5'd25, 5'd15, 5'd18, 5'd5,  5'd1,  5'd14, 5'd10, 5'd12,
      5'd22, 5'd17, 5'd2,  5'd9,  5'd3,  5'd8,  5'd21, 5'd11, 5'd0,  5'd4,
      5'd24, 5'd20, 5'd23, 5'd7,  5'd6,  5'd16
   };

   // Inverse wirings, used by the reverse (reflector-to-lampboard) stage.
   localparam letter_t W1_INV [LETTERS] = '{
      5'd9,  5'd21, 5'd8,  5'd2,  5'd18, 5'd12, 5'd1,  5'd25, 5'd11, 5'd0,
      5'd20, 5'd22, 5'd10, 5'd17, 5'd4,  5'd16, 5'd3,  5'd13, 5'd7,  5'd15,
      5'd6,  5'd14, 5'd19, 5'd5,  5'd24, 5'd23
   };

   localparam letter_t W2_INV [LETTERS] = '{
      5'd18, 5'd6,  5'd12, 5'd14, 5'd19, 5'd5,  5'd24, 5'd23, 5'd15, 5'd13,
      5'd8,  5'd17, 5'd9,  5'd0,  5'd7,  5'd3,  5'd25, 5'd11, 5'd4,  5'd1,
      5'd21, 5'd16, 5'd10, 5'd22, 5'd20, 5'd2
   };

   // True when the value encodes a real letter A..Z.
   function automatic logic is_letter(input letter_t l);
      return (l < LETTER_LIMIT);
   endfunction

   // (a + b) mod 26 for a, b in 0..25: 6-bit sum, one conditional subtract.
   function automatic letter_t add26(input letter_t a, input letter_t b);
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 6'd26) begin
         s = s - 6'd26;
      end else begin
         s = s;
      end
      return s[4:0];
   endfunction

   // (a - b) mod 26 for a, b in 0..25: 6-bit difference, one conditional add.
   function automatic letter_t sub26(input letter_t a, input letter_t b);
      logic [5:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[5]) begin
         d = d + 6'd26;
      end else begin
         d = d;
      end
      return d[4:0];
   endfunction

   // Fold a raw 5-bit position (0..31) into 0..25.
   function automatic letter_t reduce26(input letter_t v);
      letter_t r;
      if (v >= LETTER_LIMIT) begin
         r = v - LETTER_LIMIT;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/enigma_rotor_fwd_if.sv
// Handshake and position bus of the forward rotor stage.
interface enigma_rotor_fwd_if;
   import enigma_pkg::*;

   logic    load;
   letter_t load_pos1;
   letter_t load_pos2;
   logic    in_valid;
   logic    in_ready;
   letter_t in_letter;
   logic    out_valid;
   logic    out_ready;
   letter_t out_letter;
   logic    out_err;
   letter_t pos1;
   letter_t pos2;

   modport master (
      output load, load_pos1, load_pos2, in_valid, in_letter, out_ready,
      input  in_ready, out_valid, out_letter, out_err, pos1, pos2
   );

   modport slave (
      input  load, load_pos1, load_pos2, in_valid, in_letter, out_ready,
      output in_ready, out_valid, out_letter, out_err, pos1, pos2
   );

endinterface

// File: rtl/enigma_rotor_map.sv
// Combinational forward map through one rotor: out = W[(in + pos) mod 26] - pos.
// Non-letters (>= 26) pass through untouched so they reach the output as-is.
module enigma_rotor_map
   import enigma_pkg::*;
#(
   parameter int unsigned ROTOR_SEL = 1
) (
   input  letter_t i_letter,
   input  letter_t i_pos,
   output letter_t o_letter
);

   letter_t w_idx;
   letter_t w_wired;

   // Look up the wiring at the rotated contact and rotate back.
   always_comb begin
      w_idx   = 5'd0;
      w_wired = 5'd0;
      if (is_letter(i_letter)) begin
         w_idx = add26(i_letter, i_pos);
      end else begin
         w_idx = 5'd0;
      end
      case (ROTOR_SEL)
         32'd2:   w_wired = W2[w_idx];
         default: w_wired = W1[w_idx];
      endcase
      if (is_letter(i_letter)) begin
         o_letter = sub26(w_wired, i_pos);
      end else begin
         o_letter = i_letter;
      end
   end

endmodule

// File: rtl/enigma_rotor_fwd.sv
// Forward rotor path: steps the rotors per accepted letter, then encodes it
// through rotor 1 and rotor 2 over a fixed IDLE/R1/R2/OUT sequence.
module enigma_rotor_fwd
   import enigma_pkg::*;
#(
   parameter letter_t ROT1_INIT = 5'd3,
   parameter letter_t ROT2_INIT = 5'd7
) (
   input  logic            clk,
   input  logic            rst,
   enigma_rotor_fwd_if.slave bus
);

   state_t  r_state;
   state_t  w_next_state;

   letter_t r_pos1;
   letter_t r_pos2;
   letter_t r_letter;
   letter_t r_stage;
   letter_t r_out_letter;
   logic    r_out_err;
   logic    r_out_valid;
   logic    r_err;

   logic    w_in_ready;
   logic    w_accept;
   logic    w_load_en;
   logic    w_step;
   letter_t w_rot1_out;
   letter_t w_rot2_out;

   // Rotor 1 sees the already-stepped pos1, since stepping happens on the accept edge.
   enigma_rotor_map #(.ROTOR_SEL(1)) u_rotor1 (
      .i_letter (r_letter),
      .i_pos    (r_pos1),
      .o_letter (w_rot1_out)
   );

   enigma_rotor_map #(.ROTOR_SEL(2)) u_rotor2 (
      .i_letter (r_stage),
      .i_pos    (r_pos2),
      .o_letter (w_rot2_out)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_R1;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_R1:   w_next_state = ST_R2;
         ST_R2:   w_next_state = ST_OUT;
         ST_OUT: begin
            if (bus.out_ready) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_OUT;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: load has priority over a letter, and both only count in IDLE.
   always_comb begin
      w_load_en  = 1'b0;
      w_in_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_load_en  = bus.load;
            w_in_ready = ~bus.load;
         end
         default: begin
            w_load_en  = 1'b0;
            w_in_ready = 1'b0;
         end
      endcase
      w_accept = w_in_ready & bus.in_valid;
      w_step   = w_accept & is_letter(bus.in_letter);
   end

   // Rotor positions: load, or step with carry from rotor 1 into rotor 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos1 <= ROT1_INIT;
         r_pos2 <= ROT2_INIT;
      end else if (w_load_en) begin
         r_pos1 <= reduce26(bus.load_pos1);
         r_pos2 <= reduce26(bus.load_pos2);
      end else if (w_step) begin
         r_pos1 <= add26(r_pos1, 5'd1);
         if (r_pos1 == 5'd25) begin
            r_pos2 <= add26(r_pos2, 5'd1);
         end else begin
            r_pos2 <= r_pos2;
         end
      end else begin
         r_pos1 <= r_pos1;
         r_pos2 <= r_pos2;
      end
   end

   // Letter pipeline: capture, rotor 1 stage, registered result and its handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_letter     <= 5'd0;
         r_err        <= 1'b0;
         r_stage      <= 5'd0;
         r_out_letter <= 5'd0;
         r_out_err    <= 1'b0;
         r_out_valid  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_letter <= bus.in_letter;
                  r_err    <= ~is_letter(bus.in_letter);
               end else begin
                  r_letter <= r_letter;
                  r_err    <= r_err;
               end
            end
            ST_R1: begin
               r_stage <= w_rot1_out;
            end
            ST_R2: begin
               r_out_letter <= w_rot2_out;
               r_out_err    <= r_err;
               r_out_valid  <= 1'b1;
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_letter = r_out_letter;
   assign bus.out_err    = r_out_err;
   assign bus.pos1       = r_pos1;
   assign bus.pos2       = r_pos2;

endmodule

// File: tb/tb_enigma_rotor_fwd.sv
// Self-checking bench for enigma_rotor_fwd: directed cases plus randomized
// letters/positions against a plain-arithmetic rotor model and its inverse.
module tb_enigma_rotor_fwd;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   enigma_rotor_fwd_if bus_if ();

   enigma_rotor_fwd #(.ROT1_INIT(5'd3), .ROT2_INIT(5'd7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int W1 [26] = '{9,6,3,16,14,23,20,18,2,0,12,8,5,17,21,19,15,13,4,22,10,1,11,25,24,7};
   int W2 [26] = '{13,19,25,15,18,5,1,14,10,12,22,17,2,9,3,8,21,11,0,4,24,20,23,7,6,16};
   int INV1 [26];
   int INV2 [26];

   int n_cmp = 0;
   int n_err = 0;
   int m_p1  = 3;
   int m_p2  = 7;

   function automatic int rot_fwd(int sel, int c, int p);
      int v;
      v = (sel == 1) ? W1[(c + p) % 26] : W2[(c + p) % 26];
      return (v - p + 26) % 26;
   endfunction

   function automatic int rot_inv(int sel, int c, int p);
      int v;
      v = (sel == 1) ? INV1[(c + p) % 26] : INV2[(c + p) % 26];
      return (v - p + 26) % 26;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_load(input int a, input int b);
      bus_if.load      = 1'b1;
      bus_if.load_pos1 = a[4:0];
      bus_if.load_pos2 = b[4:0];
      #1;
      chk("load_blocks_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus_if.load = 1'b0;
      m_p1 = a % 26;
      m_p2 = b % 26;
      chk("load_pos1", {27'd0, bus_if.pos1}, m_p1);
      chk("load_pos2", {27'd0, bus_if.pos2}, m_p2);
   endtask

   // Send one letter at a negedge in IDLE, optionally stall the output, then drain it.
   task automatic send(input int l, input int hold, output int obs);
      int n;
      int exp_l;
      int exp_e;
      int rec;
      bus_if.in_valid  = 1'b1;
      bus_if.in_letter = l[4:0];
      #1;
      chk("in_ready_idle", {31'd0, bus_if.in_ready}, 32'd1);
      @(posedge clk);
      if (l < 26) begin
         if (m_p1 == 25) m_p2 = (m_p2 + 1) % 26;
         m_p1  = (m_p1 + 1) % 26;
         exp_l = rot_fwd(2, rot_fwd(1, l, m_p1), m_p2);
         exp_e = 0;
      end else begin
         exp_l = l;
         exp_e = 1;
      end
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      n = 0;
      while (bus_if.out_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("latency_edges_after_accept", n, 32'd2);
      obs = int'(bus_if.out_letter);
      chk("out_letter", {27'd0, bus_if.out_letter}, exp_l);
      chk("out_err", {31'd0, bus_if.out_err}, exp_e);
      chk("pos1", {27'd0, bus_if.pos1}, m_p1);
      chk("pos2", {27'd0, bus_if.pos2}, m_p2);
      if (l < 26) begin
         rec = rot_inv(1, rot_inv(2, int'(bus_if.out_letter), int'(bus_if.pos2)), int'(bus_if.pos1));
         chk("reverse_recovers_input", rec, l);
      end
      for (int h = 0; h < hold; h++) begin
         bus_if.in_valid  = 1'b1;
         bus_if.in_letter = 5'd5;
         bus_if.load      = (h == 0);
         bus_if.load_pos1 = 5'd1;
         bus_if.load_pos2 = 5'd1;
         #1;
         chk("hold_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         chk("hold_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
         chk("hold_out_letter", {27'd0, bus_if.out_letter}, exp_l);
         chk("hold_pos1", {27'd0, bus_if.pos1}, m_p1);
         chk("hold_pos2", {27'd0, bus_if.pos2}, m_p2);
      end
      bus_if.in_valid  = 1'b0;
      bus_if.load      = 1'b0;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      chk("drain_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
      chk("drain_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
   endtask

   initial begin
      int o;
      int n;
      for (int i = 0; i < 26; i++) begin
         INV1[W1[i]] = i;
         INV2[W2[i]] = i;
      end
      rst              = 1'b1;
      bus_if.load      = 1'b0;
      bus_if.load_pos1 = 5'd0;
      bus_if.load_pos2 = 5'd0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_letter = 5'd0;
      bus_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
      chk("rst_out_letter", {27'd0, bus_if.out_letter}, 32'd0);
      chk("rst_out_err", {31'd0, bus_if.out_err}, 32'd0);
      chk("rst_pos1", {27'd0, bus_if.pos1}, 32'd3);
      chk("rst_pos2", {27'd0, bus_if.pos2}, 32'd7);
      chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
      @(negedge clk);

      // Worked examples
      send(0, 0, o);
      chk("first_letter_A", o, 32'd4);
      do_load(25, 7);
      send(0, 0, o);
      chk("carry_into_rotor2", o, 32'd3);
      do_load(25, 25);
      send(0, 0, o);
      chk("rotor2_wraps", o, 32'd12);

      // Output stall with second letter and load attempts
      send(7, 5, o);

      // Invalid letter: no step, passes through with error flag
      send(30, 0, o);
      chk("invalid_passthrough", o, 32'd30);

      // Reset while in R2 discards the letter
      bus_if.in_valid  = 1'b1;
      bus_if.in_letter = 5'd11;
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
      chk("mid_rst_pos1", {27'd0, bus_if.pos1}, 32'd3);
      chk("mid_rst_pos2", {27'd0, bus_if.pos2}, 32'd7);
      @(negedge clk);
      rst  = 1'b0;
      m_p1 = 3;
      m_p2 = 7;
      repeat (4) @(negedge clk);
      chk("mid_rst_no_output", {31'd0, bus_if.out_valid}, 32'd0);

      // Load with in_valid: load wins, letter is not accepted
      bus_if.in_valid  = 1'b1;
      bus_if.in_letter = 5'd2;
      do_load(28, 10);
      bus_if.in_valid = 1'b0;
      n = 0;
      while (bus_if.out_valid !== 1'b1 && n < 4) begin
         @(negedge clk);
         n++;
      end
      chk("load_letter_dropped", {31'd0, bus_if.out_valid}, 32'd0);
      chk("load_letter_no_step", {27'd0, bus_if.pos1}, 32'd2);

      // All letters x all pos1 values, random pos2
      for (int p = 0; p < 26; p++) begin
         for (int l = 0; l < 26; l++) begin
            do_load(p, int'($urandom_range(0, 31)));
            send(l, 0, o);
         end
      end

      // Free-running random letters (including invalid), occasional random load
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         end
         send(int'($urandom_range(0, 31)), int'($urandom_range(0, 1)), o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
